// File: rtl/modmul_rr_arbiter.sv
// Round-robin front end sharing one Barrett mod-Q multiplier among NREQ requesters,
// with a two-register core pipeline and a credit-protected, tagged response FIFO.

module modmul_barrett #(
    parameter int V = 14,
    parameter int Q = 12289
) (
    input  logic [V-1:0] a,
    input  logic [V-1:0] b,
    output logic [V-1:0] p
);
    localparam int K = 2 * V;
    // mu = floor(2^K / Q); the quotient estimate is at most one short, so r0 < 2Q
    localparam longint unsigned MU = (64'd1 << K) / Q;

    logic [2*V-1:0] x;
    logic [4*V:0]   t;
    logic [2*V:0]   q_est;
    logic [2*V-1:0] qq;
    logic [2*V-1:0] r0;
    logic [2*V-1:0] r1;
    logic [2*V-1:0] r2;

    assign x     = (2*V)'(a) * (2*V)'(b);
    assign t     = (4*V+1)'(x) * (4*V+1)'(MU);
    assign q_est = t[4*V:K];
    assign qq    = q_est[2*V-1:0] * (2*V)'(Q);
    assign r0    = x - qq;
    assign r1    = (r0 >= (2*V)'(Q)) ? r0 - (2*V)'(Q) : r0;
    assign r2    = (r1 >= (2*V)'(Q)) ? r1 - (2*V)'(Q) : r1;
    assign p     = r2[V-1:0];
endmodule

module modmul_rr_arbiter #(
    parameter int V      = 14,
    parameter int Q      = 12289,
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int FDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*V-1:0] req_a,
    input  logic [NREQ*V-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [V-1:0]      rsp_p,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);
    localparam int CW = $clog2(FDEPTH + 1);
    localparam int AW = $clog2(FDEPTH);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gidx;
    logic [IDW-1:0] cand;
    logic           found;
    logic           can_issue;
    logic           xfer;
    logic [CW:0]    credit_used;

    // vld_pipe[1] is s1_v, vld_pipe[2] is s2_v
    logic [2:1]     vld_pipe;
    logic [V-1:0]   s1_a, s1_b, s2_p, core_p;
    logic [IDW-1:0] s1_id, s2_id;

    logic [V-1:0]   mem_p  [FDEPTH];
    logic [IDW-1:0] mem_id [FDEPTH];
    logic [AW-1:0]  wp, rp;
    logic [CW-1:0]  fifo_count;
    logic           push, pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] x);
        return (x == AW'(FDEPTH - 1)) ? '0 : x + AW'(1);
    endfunction

    // Registered terms only; a same-cycle pop is deliberately not credited.
    assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(vld_pipe[1]) + (CW+1)'(vld_pipe[2]);
    assign can_issue   = credit_used < (CW+1)'(FDEPTH);

    always_comb begin
        found = 1'b0;
        gidx  = ptr;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        req_ready = (found && can_issue) ? (NREQ'(1) << gidx) : '0;
    end

    assign xfer = |req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= IDW'(NREQ - 1);
            vld_pipe <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_p     <= '0;
            s2_id    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], xfer};
            if (xfer) begin
                ptr   <= gidx;
                s1_a  <= req_a[gidx*V +: V];
                s1_b  <= req_b[gidx*V +: V];
                s1_id <= gidx;
            end
            if (vld_pipe[1]) begin
                s2_p  <= core_p;
                s2_id <= s1_id;
            end
        end
    end

    modmul_barrett #(.V(V), .Q(Q)) u_core (.a(s1_a), .b(s1_b), .p(core_p));

    assign push = vld_pipe[2];
    assign pop  = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_p[wp]  <= s2_p;
            mem_id[wp] <= s2_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wp <= nxt(wp);
            if (pop)  rp <= nxt(rp);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_count == CW'(FDEPTH)));

    // Head entry is masked while empty so stale storage never shows after reset.
    assign rsp_valid = (fifo_count != '0);
    assign rsp_p     = rsp_valid ? mem_p[rp]  : '0;
    assign rsp_id    = rsp_valid ? mem_id[rp] : '0;
    assign busy      = vld_pipe[1] | vld_pipe[2] | rsp_valid;
endmodule
